// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, assembles 11-bit frames,
// checks parity/stop, and buffers good scan codes in a small FIFO popped by the processor.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned FIFO_AW    = 2,
    parameter logic [7:0]  PORT_ADDR  = 8'h0F,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2c,
    input  logic       DATA_IN,
    input  logic [7:0] POR_ID,
    input  logic       SOLICITUD,
    output logic [7:0] DATA_OUT,
    output logic       EMPTY,
    output logic       FULL,
    output logic       RX_TICK,
    output logic       FRAME_ERR,
    output logic       OVERFLOW
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRx, StCheck} state_t;

    // Input synchronisers and clock filter
    logic [1:0]            ps2c_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic                  filt_clk_q;
    logic                  fall_tick_q;

    // Frame receiver
    state_t                state_q;
    logic [3:0]            bit_cnt_q;
    logic [9:0]            rx_sr_q;
    logic [WD_W-1:0]       wdog_q;
    logic                  rx_tick_q;
    logic                  frame_err_q;

    // FIFO and read port
    logic [7:0]            mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [7:0]            data_out_q;
    logic                  overflow_q;
    logic                  sol_q;

    logic                  frame_ok;
    logic                  in_check;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop_req;
    logic                  do_pop;
    logic                  do_push;
    logic                  drop;

    always_comb begin
        frame_ok   = (^rx_sr_q[8:0]) & rx_sr_q[9];
        in_check   = (state_q == StCheck);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
        pop_req    = SOLICITUD & ~sol_q & (POR_ID == PORT_ADDR);
        do_pop     = pop_req & ~fifo_empty;
        // A same-cycle pop frees a slot, so a push into a full FIFO still succeeds.
        do_push    = in_check & frame_ok & (~fifo_full | do_pop);
        drop       = in_check & frame_ok & fifo_full & ~do_pop;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ps2c_sync_q <= 2'b11;
            data_sync_q <= 2'b11;
            filt_sr_q   <= {FILTER_LEN{1'b1}};
            filt_clk_q  <= 1'b1;
            fall_tick_q <= 1'b0;
        end else begin
            ps2c_sync_q <= {ps2c_sync_q[0], ps2c};
            data_sync_q <= {data_sync_q[0], DATA_IN};
            filt_sr_q   <= {filt_sr_q[FILTER_LEN-2:0], ps2c_sync_q[1]};
            if (&filt_sr_q) begin
                filt_clk_q <= 1'b1;
            end else if (~|filt_sr_q) begin
                filt_clk_q <= 1'b0;
            end
            fall_tick_q <= filt_clk_q & ~|filt_sr_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            rx_sr_q     <= 10'd0;
            wdog_q      <= '0;
            rx_tick_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_tick_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A high bit seen while idle is not a start bit; ignore it.
                    if (fall_tick_q && !data_sync_q[1]) begin
                        bit_cnt_q <= 4'd0;
                        wdog_q    <= '0;
                        state_q   <= StRx;
                    end
                end
                StRx: begin
                    if (fall_tick_q) begin
                        rx_sr_q <= {data_sync_q[1], rx_sr_q[9:1]};
                        wdog_q  <= '0;
                        if (bit_cnt_q == 4'd9) begin
                            state_q <= StCheck;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else if (wdog_q == WD_W'(TIMEOUT)) begin
                        state_q     <= StIdle;
                        frame_err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                    if (frame_ok) begin
                        rx_tick_q <= do_push;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr_q[PW-2:0]] <= rx_sr_q[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= 8'h00;
            overflow_q <= 1'b0;
            sol_q      <= 1'b0;
        end else begin
            sol_q <= SOLICITUD;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_req) begin
                if (!fifo_empty) begin
                    data_out_q <= mem[rd_ptr_q[PW-2:0]];
                    rd_ptr_q   <= rd_ptr_q + PW'(1);
                end else begin
                    data_out_q <= 8'h00;
                end
                overflow_q <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign DATA_OUT  = data_out_q;
    assign EMPTY     = fifo_empty;
    assign FULL      = fifo_full;
    assign RX_TICK   = rx_tick_q;
    assign FRAME_ERR = frame_err_q;
    assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, errors, FIFO fill/overflow, filtering, timeout, reads.
module tb_ps2_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ps2c = 1'b1;
    logic       DATA_IN = 1'b1;
    logic [7:0] POR_ID = 8'h00;
    logic       SOLICITUD = 1'b0;
    logic [7:0] DATA_OUT;
    logic       EMPTY;
    logic       FULL;
    logic       RX_TICK;
    logic       FRAME_ERR;
    logic       OVERFLOW;

    int tests = 0;
    int fails = 0;
    int rx_cnt = 0;
    int err_cnt = 0;

    ps2_rx_fifo dut (
        .CLK       (CLK),
        .RST       (RST),
        .ps2c      (ps2c),
        .DATA_IN   (DATA_IN),
        .POR_ID    (POR_ID),
        .SOLICITUD (SOLICITUD),
        .DATA_OUT  (DATA_OUT),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .RX_TICK   (RX_TICK),
        .FRAME_ERR (FRAME_ERR),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RX_TICK === 1'b1) rx_cnt++;
        if (FRAME_ERR === 1'b1) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                             input logic stop);
        logic p;
        p = (~^d) ^ bad_par;
        return {stop, p, d, 1'b0};
    endfunction

    // Sends the first nbits of a frame, LSB (start bit) first; optional ps2c glitch on one bit.
    task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLK);
            DATA_IN = f[i];
            if (i == glitch_bit) begin
                wait_clk(3);
                ps2c = 1'b0;
                wait_clk(6);
                ps2c = 1'b1;
                wait_clk(3);
            end else begin
                wait_clk(12);
            end
            ps2c = 1'b0;
            wait_clk(20);
            ps2c = 1'b1;
            wait_clk(10);
        end
        DATA_IN = 1'b1;
        wait_clk(30);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int glitch_bit);
        send_bits(mk_frame(d, bad_par, stop), 11, glitch_bit);
    endtask

    task automatic do_read(input logic [7:0] addr);
        @(negedge CLK);
        POR_ID    = addr;
        SOLICITUD = 1'b1;
        @(negedge CLK);
        SOLICITUD = 1'b0;
        POR_ID    = 8'h00;
    endtask

    task automatic test_reset;
        tests++; if (DATA_OUT !== 8'h00) begin $display("FAIL reset_dout got %h want 00", DATA_OUT); fails++; end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL reset_empty got %b want 1", EMPTY); fails++; end
        tests++; if (FULL !== 1'b0) begin $display("FAIL reset_full got %b want 0", FULL); fails++; end
        tests++; if (RX_TICK !== 1'b0) begin $display("FAIL reset_rxtick got %b want 0", RX_TICK); fails++; end
        tests++; if (FRAME_ERR !== 1'b0) begin $display("FAIL reset_ferr got %b want 0", FRAME_ERR); fails++; end
        tests++; if (OVERFLOW !== 1'b0) begin $display("FAIL reset_ovf got %b want 0", OVERFLOW); fails++; end
    endtask

    task automatic test_basic_frame;
        int rx0, er0;
        rx0 = rx_cnt; er0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        tests++; if (rx_cnt - rx0 !== 1) begin $display("FAIL basic_rxtick got %0d want 1", rx_cnt - rx0); fails++; end
        tests++; if (err_cnt - er0 !== 0) begin $display("FAIL basic_ferr got %0d want 0", err_cnt - er0); fails++; end
        tests++; if (EMPTY !== 1'b0) begin $display("FAIL basic_notempty got %b want 0", EMPTY); fails++; end
        do_read(8'h0F);
        tests++; if (DATA_OUT !== 8'h1C) begin $display("FAIL basic_dout got %h want 1c", DATA_OUT); fails++; end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL basic_empty got %b want 1", EMPTY); fails++; end
    endtask

    task automatic test_frame_errors;
        int rx0, er0;
        rx0 = rx_cnt; er0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        tests++; if (err_cnt - er0 !== 1) begin $display("FAIL parity_ferr got %0d want 1", err_cnt - er0); fails++; end
        tests++; if (rx_cnt - rx0 !== 0) begin $display("FAIL parity_rxtick got %0d want 0", rx_cnt - rx0); fails++; end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL parity_empty got %b want 1", EMPTY); fails++; end
        rx0 = rx_cnt; er0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        tests++; if (err_cnt - er0 !== 1) begin $display("FAIL stop_ferr got %0d want 1", err_cnt - er0); fails++; end
        tests++; if (rx_cnt - rx0 !== 0) begin $display("FAIL stop_rxtick got %0d want 0", rx_cnt - rx0); fails++; end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL stop_empty got %b want 1", EMPTY); fails++; end
    endtask

    task automatic test_fill_overflow;
        logic [7:0] exp [4];
        int rx0, er0;
        exp[0] = 8'h1C; exp[1] = 8'h32; exp[2] = 8'h21; exp[3] = 8'h23;
        rx0 = rx_cnt;
        for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b0, 1'b1, -1);
        tests++; if (rx_cnt - rx0 !== 4) begin $display("FAIL fill_rxtick got %0d want 4", rx_cnt - rx0); fails++; end
        tests++; if (FULL !== 1'b1) begin $display("FAIL fill_full got %b want 1", FULL); fails++; end
        tests++; if (OVERFLOW !== 1'b0) begin $display("FAIL fill_ovf got %b want 0", OVERFLOW); fails++; end
        rx0 = rx_cnt; er0 = err_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        tests++; if (OVERFLOW !== 1'b1) begin $display("FAIL ovf_set got %b want 1", OVERFLOW); fails++; end
        tests++; if (rx_cnt - rx0 !== 0) begin $display("FAIL ovf_rxtick got %0d want 0", rx_cnt - rx0); fails++; end
        tests++; if (err_cnt - er0 !== 0) begin $display("FAIL ovf_ferr got %0d want 0", err_cnt - er0); fails++; end
        for (int i = 0; i < 4; i++) begin
            do_read(8'h0F);
            tests++; if (DATA_OUT !== exp[i]) begin $display("FAIL drain_%0d got %h want %h", i, DATA_OUT, exp[i]); fails++; end
            if (i == 0) begin
                tests++; if (OVERFLOW !== 1'b0) begin $display("FAIL ovf_clear got %b want 0", OVERFLOW); fails++; end
            end
        end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL drain_empty got %b want 1", EMPTY); fails++; end
        tests++; if (FULL !== 1'b0) begin $display("FAIL drain_full got %b want 0", FULL); fails++; end
    endtask

    task automatic test_glitch;
        int rx0, er0;
        rx0 = rx_cnt; er0 = err_cnt;
        @(negedge CLK);
        ps2c = 1'b0;
        wait_clk(6);
        ps2c = 1'b1;
        wait_clk(40);
        tests++; if (rx_cnt - rx0 !== 0 || err_cnt - er0 !== 0) begin
            $display("FAIL idle_glitch got rx %0d err %0d want 0 0", rx_cnt - rx0, err_cnt - er0); fails++; end
        send_frame(8'h32, 1'b0, 1'b1, 4);
        tests++; if (rx_cnt - rx0 !== 1) begin $display("FAIL glitch_rxtick got %0d want 1", rx_cnt - rx0); fails++; end
        tests++; if (err_cnt - er0 !== 0) begin $display("FAIL glitch_ferr got %0d want 0", err_cnt - er0); fails++; end
        do_read(8'h0F);
        tests++; if (DATA_OUT !== 8'h32) begin $display("FAIL glitch_dout got %h want 32", DATA_OUT); fails++; end
    endtask

    task automatic test_timeout;
        int er0;
        er0 = err_cnt;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5, -1);
        wait_clk(40000);
        tests++; if (err_cnt - er0 !== 0) begin $display("FAIL timeout_early got %0d want 0", err_cnt - er0); fails++; end
        wait_clk(10100);
        tests++; if (err_cnt - er0 !== 1) begin $display("FAIL timeout_ferr got %0d want 1", err_cnt - er0); fails++; end
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        tests++; if (err_cnt - er0 !== 1) begin $display("FAIL timeout_next_ferr got %0d want 1", err_cnt - er0); fails++; end
        do_read(8'h0F);
        tests++; if (DATA_OUT !== 8'h1C) begin $display("FAIL timeout_next got %h want 1c", DATA_OUT); fails++; end
    endtask

    task automatic test_port_mismatch;
        send_frame(8'h21, 1'b0, 1'b1, -1);
        do_read(8'h10);
        wait_clk(2);
        tests++; if (DATA_OUT !== 8'h1C) begin $display("FAIL mismatch_dout got %h want 1c", DATA_OUT); fails++; end
        tests++; if (EMPTY !== 1'b0) begin $display("FAIL mismatch_empty got %b want 0", EMPTY); fails++; end
        do_read(8'h0F);
        tests++; if (DATA_OUT !== 8'h21) begin $display("FAIL mismatch_then got %h want 21", DATA_OUT); fails++; end
    endtask

    task automatic test_held_request;
        send_frame(8'h23, 1'b0, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        @(negedge CLK);
        POR_ID    = 8'h0F;
        SOLICITUD = 1'b1;
        wait_clk(10);
        SOLICITUD = 1'b0;
        POR_ID    = 8'h00;
        wait_clk(2);
        tests++; if (DATA_OUT !== 8'h23) begin $display("FAIL held_dout got %h want 23", DATA_OUT); fails++; end
        tests++; if (EMPTY !== 1'b0) begin $display("FAIL held_once got empty %b want 0", EMPTY); fails++; end
        do_read(8'h0F);
        tests++; if (DATA_OUT !== 8'h1C) begin $display("FAIL held_next got %h want 1c", DATA_OUT); fails++; end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL held_empty got %b want 1", EMPTY); fails++; end
    endtask

    task automatic test_reset_midframe;
        int rx0, er0;
        send_frame(8'h32, 1'b0, 1'b1, -1);
        send_bits(mk_frame(8'h23, 1'b0, 1'b1), 4, -1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        tests++; if (DATA_OUT !== 8'h00) begin $display("FAIL rstmid_dout got %h want 00", DATA_OUT); fails++; end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL rstmid_empty got %b want 1", EMPTY); fails++; end
        tests++; if (FULL !== 1'b0 || OVERFLOW !== 1'b0 || RX_TICK !== 1'b0 || FRAME_ERR !== 1'b0) begin
            $display("FAIL rstmid_flags got full %b ovf %b tick %b ferr %b want 0 0 0 0",
                     FULL, OVERFLOW, RX_TICK, FRAME_ERR); fails++; end
        rx0 = rx_cnt; er0 = err_cnt;
        send_frame(8'h21, 1'b0, 1'b1, -1);
        tests++; if (rx_cnt - rx0 !== 1 || err_cnt - er0 !== 0) begin
            $display("FAIL rstmid_next got rx %0d err %0d want 1 0", rx_cnt - rx0, err_cnt - er0); fails++; end
        do_read(8'h0F);
        tests++; if (DATA_OUT !== 8'h21) begin $display("FAIL rstmid_dout2 got %h want 21", DATA_OUT); fails++; end
    endtask

    task automatic test_empty_read;
        do_read(8'h0F);
        tests++; if (DATA_OUT !== 8'h00) begin $display("FAIL empty_read got %h want 00", DATA_OUT); fails++; end
        tests++; if (EMPTY !== 1'b1) begin $display("FAIL empty_read_empty got %b want 1", EMPTY); fails++; end
    endtask

    initial begin
        wait_clk(5);
        RST = 1'b0;
        wait_clk(2);
        test_reset();
        test_basic_frame();
        test_frame_errors();
        test_fill_overflow();
        test_glitch();
        test_timeout();
        test_port_mismatch();
        test_held_request();
        test_reset_midframe();
        test_empty_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
